// File: rtl/sop_sweep_pkg.sv
// Shared types and sizing for the SOP truth-table sweep controller.
package sop_sweep_pkg;

    localparam int NUM_VECTORS = 8;
    localparam int IDX_W       = 3;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sop_sweep_ctrl.sv
// Sweeps {x,y,z} through all eight input vectors of a 3-input SOP block,
// captures f per vector into table_out and compares against a golden table.
module sop_sweep_ctrl
    import sop_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic       f,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_VECTORS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_q, exp_d;
    logic [7:0]       table_q, table_d;
    logic [2:0]       xyz_q, xyz_d;
    logic             done_q, done_d;
    logic             match_q, match_d;
    logic [7:0]       mask_q, mask_d;

    // Next-state, sweep bookkeeping and registered-output precomputation.
    // Results are compared against the table including the final sample,
    // so match/mask become valid on the same edge that enters DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        table_d = table_q;
        match_d = match_q;
        mask_d  = mask_q;
        done_d  = 1'b0;
        xyz_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d   = expected;
                    table_d = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SAMPLE: begin
                table_d[idx_q] = f;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    match_d = (table_d == exp_q);
                    mask_d  = table_d ^ exp_q;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_DRIVE || state_d == ST_SAMPLE) begin
            xyz_d = idx_d;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            xyz_q   <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            table_q <= table_d;
            xyz_q   <= xyz_d;
            done_q  <= done_d;
            match_q <= match_d;
            mask_q  <= mask_d;
        end
    end

    // busy is decoded from the state register only.
    always_comb begin
        busy = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    end

    assign x             = xyz_q[2];
    assign y             = xyz_q[1];
    assign z             = xyz_q[0];
    assign done          = done_q;
    assign table_out     = table_q;
    assign match         = match_q;
    assign mismatch_mask = mask_q;

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Directed bench for sop_sweep_ctrl: default-settle instance (index 0) driving
// a combinational f = x&y | z, and a SETTLE_CYCLES=3 instance (index 1)
// driving the same function through a 2-cycle delay.
module tb_sop_sweep_ctrl;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      st = '0;
    logic [1:0][7:0] ex = '0;
    logic [1:0]      xo, yo, zo, fo, bz, dn, mt;
    logic [1:0][7:0] tbo, mko;
    logic            d1 = 1'b0, d2 = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sop_sweep_ctrl u_dut1 (
        .clk(clk), .rst(rst), .start(st[0]), .expected(ex[0]),
        .x(xo[0]), .y(yo[0]), .z(zo[0]), .f(fo[0]),
        .busy(bz[0]), .done(dn[0]), .table_out(tbo[0]),
        .match(mt[0]), .mismatch_mask(mko[0])
    );

    sop_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st[1]), .expected(ex[1]),
        .x(xo[1]), .y(yo[1]), .z(zo[1]), .f(fo[1]),
        .busy(bz[1]), .done(dn[1]), .table_out(tbo[1]),
        .match(mt[1]), .mismatch_mask(mko[1])
    );

    assign fo[0] = (xo[0] & yo[0]) | zo[0];
    always @(posedge clk) begin
        d1 <= (xo[1] & yo[1]) | zo[1];
        d2 <= d1;
    end
    assign fo[1] = d2;

    typedef struct {
        logic [7:0] exp_in;
        logic [7:0] tbl;
        logic       m;
        logic [7:0] mask;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_idle_zero(input int d, input string tag);
        chk({tag, "_busy"}, 32'(bz[d]), 0);
        chk({tag, "_done"}, 32'(dn[d]), 0);
        chk({tag, "_xyz"}, 32'({xo[d], yo[d], zo[d]}), 0);
        chk({tag, "_table"}, 32'(tbo[d]), 0);
        chk({tag, "_match"}, 32'(mt[d]), 0);
        chk({tag, "_mask"}, 32'(mko[d]), 0);
    endtask

    // Full sweep on instance d; checks latency, x/y/z stepping, single-cycle
    // done, and that results hold afterwards. Expected input is inverted
    // right after start is accepted to show it was captured.
    task automatic do_sweep(input int d, input logic [7:0] exp_v, input bit extra,
                            input string tag);
        int per, n, lat, bad;
        per = (d == 1) ? 4 : 2;
        @(negedge clk);
        ex[d] = exp_v;
        st[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[d] = 1'b0;
        ex[d] = ~exp_v;
        n = 0; lat = -1; bad = 0;
        while (n < 200) begin
            if (dn[d]) begin
                lat = n;
                break;
            end
            if (n < 8 * per) begin
                if (!bz[d] || {xo[d], yo[d], zo[d]} != 3'(n / per)) bad++;
            end
            st[d] = extra && (n == 5);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(8 * per));
        chk({tag, "_xyz_steps_bad"}, 32'(bad), 0);
        chk({tag, "_done_xyz"}, 32'({xo[d], yo[d], zo[d], bz[d]}), 0);
        if (extra) st[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[d] = 1'b0;
        chk({tag, "_done_pulse"}, 32'(dn[d]), 0);
        repeat (4) @(negedge clk);
        chk({tag, "_no_restart_busy"}, 32'(bz[d]), 0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'hEA, 8'hEA, 1'b1, 8'h00};
        vecs[1] = '{8'hEB, 8'hEA, 1'b0, 8'h01};
        vecs[2] = '{8'h00, 8'hEA, 1'b0, 8'hEA};
        vecs[3] = '{8'hFF, 8'hEA, 1'b0, 8'h15};
        vecs[4] = '{8'h6A, 8'hEA, 1'b0, 8'h80};

        // Reset held two cycles with start asserted.
        rst = 1'b1;
        st = 2'b11;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check_idle_zero(0, "rst1");
            check_idle_zero(1, "rst3");
        end
        rst = 1'b0;
        st = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_sweep1", 32'(bz[0]), 0);
        chk("rst_no_sweep3", 32'(bz[1]), 0);

        // Table-driven sweeps on the default instance.
        for (int i = 0; i < 5; i++) begin
            do_sweep(0, vecs[i].exp_in, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_table", i), 32'(tbo[0]), 32'(vecs[i].tbl));
            chk($sformatf("vec%0d_match", i), 32'(mt[0]), 32'(vecs[i].m));
            chk($sformatf("vec%0d_mask", i), 32'(mko[0]), 32'(vecs[i].mask));
        end

        // Start pulses mid-sweep and during DONE are ignored.
        do_sweep(0, 8'hEA, 1'b1, "ign");
        chk("ign_table", 32'(tbo[0]), 32'h00EA);
        chk("ign_match", 32'(mt[0]), 1);
        chk("ign_mask", 32'(mko[0]), 0);

        // Reset while idx=4.
        @(negedge clk);
        ex[0] = 8'hEA;
        st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[0] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("mid_xyz", 32'({xo[0], yo[0], zo[0]}), 4);
        chk("mid_table", 32'(tbo[0]), 32'h0A);
        chk("mid_match_held", 32'(mt[0]), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero(0, "midrst");
        do_sweep(0, 8'hEA, 1'b0, "post");
        chk("post_table", 32'(tbo[0]), 32'h00EA);
        chk("post_match", 32'(mt[0]), 1);
        chk("post_mask", 32'(mko[0]), 0);

        // SETTLE_CYCLES=3 with a 2-cycle delayed f.
        do_sweep(1, 8'hEA, 1'b0, "s3");
        chk("s3_table", 32'(tbo[1]), 32'h00EA);
        chk("s3_match", 32'(mt[1]), 1);
        chk("s3_mask", 32'(mko[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
